// File: rtl/spm_pkg.sv
// Shared definitions for the self-programming (SPM) sequencer.
// Contents:
//   spm_state_e  - sequencer states
//   *_BIT        - SPMCSR bit positions
//   BK_*         - flash bank-select encodings driven on BkSel
package spm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        ADR_LO = 3'd2,
        ADR_HI = 3'd3,
        BUF_LO = 3'd4,
        BUF_HI = 3'd5,
        OP     = 3'd6,
        DONE   = 3'd7
    } spm_state_e;

    // SPMCSR bit positions
    localparam int unsigned SPMIE_BIT  = 7;
    localparam int unsigned RWWSB_BIT  = 6;
    localparam int unsigned RWWSRE_BIT = 4;
    localparam int unsigned PGWRT_BIT  = 2;
    localparam int unsigned PGERS_BIT  = 1;
    localparam int unsigned SPMEN_BIT  = 0;

    // BkSel encodings
    localparam logic [1:0] BK_RD      = 2'b00;
    localparam logic [1:0] BK_NRWW_WR = 2'b01;
    localparam logic [1:0] BK_RWW_WR  = 2'b10;
    localparam logic [1:0] BK_EXCL    = 2'b11;

endpackage

// File: rtl/spm_flash_ctrl_if.sv
// Flash byte-bus between the SPM sequencer and the flash memory model.
// Signals:
//   DBI[7:0]  - data/address byte      DB_WR    - write strobe
//   Adr_0     - byte select (0=lo)     EnAdrLat - address latch enable
//   EnBuf     - write-buffer enable    Erase    - page erase
//   Prog      - page write             BkSel    - bank select
// Modports: master = sequencer (drives all), slave = flash (samples all).
// All signals are registered in the master and only change on clk.
interface spm_flash_ctrl_if;
    logic [7:0] DBI;
    logic       DB_WR;
    logic       Adr_0;
    logic       EnAdrLat;
    logic       EnBuf;
    logic       Erase;
    logic       Prog;
    logic [1:0] BkSel;

    modport master (
        output DBI, DB_WR, Adr_0, EnAdrLat, EnBuf, Erase, Prog, BkSel
    );

    modport slave (
        input DBI, DB_WR, Adr_0, EnAdrLat, EnBuf, Erase, Prog, BkSel
    );
endinterface

// File: rtl/spm_timer.sv
// Loadable down-counter shared by the SPM arm window and the erase/program
// hold time. Load has priority over decrement; the count saturates at zero.
// Ports:
//   clk, nrst   - clock, async active-low reset (count -> 0)
//   load_i      - load load_val_i this cycle
//   load_val_i  - value to load
//   dec_i       - decrement by one (ignored at zero)
//   cnt_o       - current count
//   zero_o      - count is zero
//   last_o      - count is one (the next decrement reaches zero)
module spm_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o,
    output logic         last_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == W'(1));
endmodule

// File: rtl/spm_flash_ctrl.sv
// SPM sequencer: turns SPMCSR writes and SPM instruction strobes into the
// flash byte-bus protocol, times page erase / page write, maintains RWWSB and
// stalls the core during NRWW operations.
// Ports:
//   clk, nrst              - clock, async active-low reset
//   spmcsr_we/_din/_dout   - SPMCSR write strobe, write data, read value
//   spm_exec               - one-cycle SPM instruction strobe
//   z_ptr, r1r0            - Z byte address (bit 15 ignored), R1:R0 data
//   fbus                   - flash byte-bus (master side)
//   cpu_halt               - core stall during NRWW erase/write
//   spm_busy               - sequencer not in IDLE
//   spm_irq                - SPMIE & ~SPMEN
// Every output is taken straight from a flop.
module spm_flash_ctrl
    import spm_pkg::*;
#(
    parameter int unsigned PROG_CYCLES = 51040,
    parameter int unsigned ARM_WINDOW  = 4,
    parameter logic [2:0]  NRWW_TOP    = 3'b111
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    spmcsr_we,
    input  logic [7:0]              spmcsr_din,
    output logic [7:0]              spmcsr_dout,
    input  logic                    spm_exec,
    input  logic [15:0]             z_ptr,
    input  logic [15:0]             r1r0,
    spm_flash_ctrl_if.master        fbus,
    output logic                    cpu_halt,
    output logic                    spm_busy,
    output logic                    spm_irq
);
    localparam int unsigned TMR_MAX = (PROG_CYCLES > ARM_WINDOW) ? PROG_CYCLES : ARM_WINDOW;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);

    spm_state_e  state_q, state_d;
    logic        spmie_q, spmie_d;
    logic        spmen_q, spmen_d;
    logic        rwwsre_q, rwwsre_d;
    logic        pgwrt_q, pgwrt_d;
    logic        pgers_q, pgers_d;
    logic        rwwsb_q, rwwsb_d;
    logic [14:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic        is_op_q, is_op_d;      // 1: erase/write, 0: buffer fill
    logic        op_erase_q, op_erase_d; // 1: erase, 0: page write
    logic [7:0]  dbi_q, dbi_d;
    logic        db_wr_q, db_wr_d;
    logic        adr0_q, adr0_d;
    logic        en_adr_lat_q, en_adr_lat_d;
    logic        en_buf_q, en_buf_d;
    logic        erase_q, erase_d;
    logic        prog_q, prog_d;
    logic [1:0]  bksel_q, bksel_d;
    logic        halt_q, halt_d;
    logic        busy_q, busy_d;
    logic        irq_q, irq_d;

    logic          tmr_load, tmr_dec, tmr_zero, tmr_last;
    logic [TW-1:0] tmr_val, tmr_cnt;
    logic          clr_cmd;
    logic          is_nrww;
    logic          unused_ok;

    assign unused_ok = ^{z_ptr[15], spmcsr_din[6:5], spmcsr_din[3], tmr_cnt};

    spm_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .nrst       (nrst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .cnt_o      (tmr_cnt),
        .zero_o     (tmr_zero),
        .last_o     (tmr_last)
    );

    // Section decode on the live Z value, used in the cycle spm_exec is taken.
    assign is_nrww = (z_ptr[14:12] == NRWW_TOP);

    always_comb begin
        state_d      = state_q;
        spmie_d      = spmie_q;
        spmen_d      = spmen_q;
        rwwsre_d     = rwwsre_q;
        pgwrt_d      = pgwrt_q;
        pgers_d      = pgers_q;
        rwwsb_d      = rwwsb_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        is_op_d      = is_op_q;
        op_erase_d   = op_erase_q;
        erase_d      = erase_q;
        prog_d       = prog_q;
        bksel_d      = bksel_q;
        halt_d       = halt_q;
        // Bus strobes are single-cycle pulses: default low every cycle.
        dbi_d        = 8'h00;
        db_wr_d      = 1'b0;
        adr0_d       = 1'b0;
        en_adr_lat_d = 1'b0;
        en_buf_d     = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_dec      = 1'b0;
        clr_cmd      = 1'b0;

        // SPMIE is writable in every state except while armed.
        if (spmcsr_we && (state_q != ARMED)) begin
            spmie_d = spmcsr_din[SPMIE_BIT];
        end

        case (state_q)
            IDLE: begin
                if (spmcsr_we && spmcsr_din[SPMEN_BIT]) begin
                    spmen_d  = 1'b1;
                    rwwsre_d = spmcsr_din[RWWSRE_BIT];
                    pgwrt_d  = spmcsr_din[PGWRT_BIT];
                    pgers_d  = spmcsr_din[PGERS_BIT];
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ARM_WINDOW);
                    state_d  = ARMED;
                end
            end

            ARMED: begin
                if (spm_exec) begin
                    adr_d = z_ptr[14:0];
                    dat_d = r1r0;
                    case ({rwwsre_q, pgwrt_q, pgers_q})
                        3'b000, 3'b001, 3'b010: begin
                            // Address low byte goes out in the ADR_LO cycle.
                            state_d      = ADR_LO;
                            db_wr_d      = 1'b1;
                            en_adr_lat_d = 1'b1;
                            dbi_d        = z_ptr[7:0];
                            is_op_d      = pgwrt_q | pgers_q;
                            op_erase_d   = pgers_q;
                            if (pgwrt_q | pgers_q) begin
                                bksel_d = is_nrww ? BK_EXCL : BK_RWW_WR;
                                halt_d  = is_nrww;
                                if (!is_nrww) begin
                                    rwwsb_d = 1'b1;
                                end
                            end
                        end
                        3'b100: begin
                            // Operations are strictly sequential, so none can be
                            // pending here: re-enabling RWW always succeeds.
                            rwwsb_d = 1'b0;
                            clr_cmd = 1'b1;
                            state_d = IDLE;
                        end
                        default: begin
                            clr_cmd = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end else if (tmr_last || tmr_zero) begin
                    clr_cmd = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ADR_LO: begin
                state_d      = ADR_HI;
                db_wr_d      = 1'b1;
                en_adr_lat_d = 1'b1;
                adr0_d       = 1'b1;
                dbi_d        = {1'b0, adr_q[14:8]};
            end

            ADR_HI: begin
                if (is_op_q) begin
                    state_d  = OP;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PROG_CYCLES);
                    erase_d  = op_erase_q;
                    prog_d   = ~op_erase_q;
                end else begin
                    state_d  = BUF_LO;
                    db_wr_d  = 1'b1;
                    en_buf_d = 1'b1;
                    dbi_d    = dat_q[7:0];
                end
            end

            BUF_LO: begin
                state_d  = BUF_HI;
                db_wr_d  = 1'b1;
                en_buf_d = 1'b1;
                adr0_d   = 1'b1;
                dbi_d    = dat_q[15:8];
            end

            BUF_HI: begin
                state_d = DONE;
                clr_cmd = 1'b1;
            end

            OP: begin
                // Counter loaded with PROG_CYCLES on entry; leaving at count 1
                // gives exactly PROG_CYCLES cycles of Erase/Prog.
                if (tmr_last || tmr_zero) begin
                    erase_d = 1'b0;
                    prog_d  = 1'b0;
                    bksel_d = BK_RD;
                    halt_d  = 1'b0;
                    clr_cmd = 1'b1;
                    state_d = DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr_cmd) begin
            spmen_d  = 1'b0;
            rwwsre_d = 1'b0;
            pgwrt_d  = 1'b0;
            pgers_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
        irq_d  = spmie_d & ~spmen_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            spmie_q      <= 1'b0;
            spmen_q      <= 1'b0;
            rwwsre_q     <= 1'b0;
            pgwrt_q      <= 1'b0;
            pgers_q      <= 1'b0;
            rwwsb_q      <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            is_op_q      <= 1'b0;
            op_erase_q   <= 1'b0;
            dbi_q        <= 8'h00;
            db_wr_q      <= 1'b0;
            adr0_q       <= 1'b0;
            en_adr_lat_q <= 1'b0;
            en_buf_q     <= 1'b0;
            erase_q      <= 1'b0;
            prog_q       <= 1'b0;
            bksel_q      <= BK_RD;
            halt_q       <= 1'b0;
            busy_q       <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            spmie_q      <= spmie_d;
            spmen_q      <= spmen_d;
            rwwsre_q     <= rwwsre_d;
            pgwrt_q      <= pgwrt_d;
            pgers_q      <= pgers_d;
            rwwsb_q      <= rwwsb_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            is_op_q      <= is_op_d;
            op_erase_q   <= op_erase_d;
            dbi_q        <= dbi_d;
            db_wr_q      <= db_wr_d;
            adr0_q       <= adr0_d;
            en_adr_lat_q <= en_adr_lat_d;
            en_buf_q     <= en_buf_d;
            erase_q      <= erase_d;
            prog_q       <= prog_d;
            bksel_q      <= bksel_d;
            halt_q       <= halt_d;
            busy_q       <= busy_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        spmcsr_dout             = 8'h00;
        spmcsr_dout[SPMIE_BIT]  = spmie_q;
        spmcsr_dout[RWWSB_BIT]  = rwwsb_q;
        spmcsr_dout[RWWSRE_BIT] = rwwsre_q;
        spmcsr_dout[PGWRT_BIT]  = pgwrt_q;
        spmcsr_dout[PGERS_BIT]  = pgers_q;
        spmcsr_dout[SPMEN_BIT]  = spmen_q;
    end

    assign fbus.DBI      = dbi_q;
    assign fbus.DB_WR    = db_wr_q;
    assign fbus.Adr_0    = adr0_q;
    assign fbus.EnAdrLat = en_adr_lat_q;
    assign fbus.EnBuf    = en_buf_q;
    assign fbus.Erase    = erase_q;
    assign fbus.Prog     = prog_q;
    assign fbus.BkSel    = bksel_q;
    assign cpu_halt      = halt_q;
    assign spm_busy      = busy_q;
    assign spm_irq       = irq_q;
endmodule

// File: tb/tb_spm_flash_ctrl.sv
// Directed bench for spm_flash_ctrl with a byte-bus scoreboard, a small
// page-buffer model and an erase/write completion counter.
module tb_spm_flash_ctrl;
    localparam int unsigned PROG = 20;
    localparam int W = 11; // {EnAdrLat, EnBuf, Adr_0, DBI}

    logic        clk;
    logic        nrst;
    logic        spmcsr_we;
    logic [7:0]  spmcsr_din;
    logic [7:0]  spmcsr_dout;
    logic        spm_exec;
    logic [15:0] z_ptr;
    logic [15:0] r1r0;
    logic        cpu_halt;
    logic        spm_busy;
    logic        spm_irq;

    spm_flash_ctrl_if fbus ();

    spm_flash_ctrl #(
        .PROG_CYCLES (PROG),
        .ARM_WINDOW  (4),
        .NRWW_TOP    (3'b111)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .spmcsr_we   (spmcsr_we),
        .spmcsr_din  (spmcsr_din),
        .spmcsr_dout (spmcsr_dout),
        .spm_exec    (spm_exec),
        .z_ptr       (z_ptr),
        .r1r0        (r1r0),
        .fbus        (fbus),
        .cpu_halt    (cpu_halt),
        .spm_busy    (spm_busy),
        .spm_irq     (spm_irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   page_buf [0:127];
    logic [7:0]   lat_lo;
    int           commits;
    logic         op_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] beat(input logic lat, input logic bf, input logic a0, input logic [7:0] d);
        return {lat, bf, a0, d};
    endfunction

    // Bus monitor: every DB_WR beat must match the head of the expected queue.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (nrst && fbus.DB_WR) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("bus_beat", 32'({fbus.EnAdrLat, fbus.EnBuf, fbus.Adr_0, fbus.DBI}), 32'(e));
            end
            if (fbus.EnAdrLat && !fbus.Adr_0) lat_lo = fbus.DBI;
            if (fbus.EnBuf) page_buf[{lat_lo[6:1], fbus.Adr_0}] = fbus.DBI;
        end
    end

    // Flash model: an erase/write commits only if its strobe falls while out of reset.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op_prev <= 1'b0;
        end else begin
            if (op_prev && !(fbus.Erase || fbus.Prog)) commits <= commits + 1;
            op_prev <= fbus.Erase || fbus.Prog;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic csr_write(input logic [7:0] d);
        @(posedge clk); #1;
        spmcsr_we = 1'b1; spmcsr_din = d;
        @(posedge clk); #1;
        spmcsr_we = 1'b0; spmcsr_din = 8'h00;
    endtask

    task automatic do_exec(input logic [15:0] z, input logic [15:0] d);
        @(posedge clk); #1;
        spm_exec = 1'b1; z_ptr = z; r1r0 = d;
        @(posedge clk); #1;
        spm_exec = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (spm_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(spm_busy), 32'd0);
    endtask

    // Counts Erase/Prog high cycles and per-cycle deviations of BkSel/cpu_halt/strobe.
    task automatic watch_op(input logic [1:0] ebk, input logic ehalt, input logic eerase,
                            output int hi, output int bad);
        int n;
        hi = 0; bad = 0; n = 0;
        @(negedge clk);
        while (!(fbus.Erase || fbus.Prog) && n < 50) begin
            @(negedge clk);
            n++;
        end
        while ((fbus.Erase || fbus.Prog) && n < 300) begin
            hi++;
            if (fbus.BkSel !== ebk || cpu_halt !== ehalt ||
                fbus.Erase !== eerase || fbus.Prog !== ~eerase) bad++;
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hi, bad, n;
        nrst = 1'b0; spmcsr_we = 1'b0; spmcsr_din = 8'h00;
        spm_exec = 1'b0; z_ptr = 16'h0000; r1r0 = 16'h0000;
        commits = 0; lat_lo = 8'h00;
        for (int i = 0; i < 128; i++) page_buf[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(spmcsr_dout), 32'h00);
        chk("rst_bus", 32'({fbus.DBI, fbus.DB_WR, fbus.Adr_0, fbus.EnAdrLat, fbus.EnBuf}), 32'h0);
        chk("rst_op", 32'({fbus.Erase, fbus.Prog, fbus.BkSel}), 32'h0);
        chk("rst_misc", 32'({cpu_halt, spm_busy, spm_irq}), 32'h0);
        @(posedge clk); #1; nrst = 1'b1;

        // Arm window expires: SPMEN held 4 cycles, then cleared, no bus beats
        csr_write(8'h01);
        @(negedge clk);
        chk("arm_spmen_set", 32'(spmcsr_dout), 32'h01);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("arm_spmen_last", 32'(spmcsr_dout), 32'h01);
        @(posedge clk);
        @(negedge clk);
        chk("arm_expired", 32'(spmcsr_dout), 32'h00);
        chk("arm_idle", 32'(spm_busy), 32'd0);

        // Buffer fill
        csr_write(8'h01);
        exp_q.push_back(beat(1'b1, 1'b0, 1'b0, 8'h46));
        exp_q.push_back(beat(1'b1, 1'b0, 1'b1, 8'h00));
        exp_q.push_back(beat(1'b0, 1'b1, 1'b0, 8'hEF));
        exp_q.push_back(beat(1'b0, 1'b1, 1'b1, 8'hBE));
        do_exec(16'h0046, 16'hBEEF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("fill_spmen_before_done", 32'(spmcsr_dout), 32'h01);
        @(posedge clk);
        @(negedge clk);
        chk("fill_done_spmen", 32'(spmcsr_dout), 32'h00);
        chk("fill_done_busy", 32'(spm_busy), 32'd1);
        @(negedge clk);
        chk("fill_idle", 32'(spm_busy), 32'd0);
        chk("fill_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("fill_buf_lo", 32'(page_buf[70]), 32'hEF);
        chk("fill_buf_hi", 32'(page_buf[71]), 32'hBE);

        // Conflicting command bits: no-op
        csr_write(8'h07);
        @(negedge clk);
        chk("multi_armed", 32'(spmcsr_dout), 32'h07);
        do_exec(16'h0123, 16'h5555);
        @(negedge clk);
        chk("multi_cleared", 32'(spmcsr_dout), 32'h00);
        chk("multi_idle", 32'(spm_busy), 32'd0);

        // RWW page erase
        csr_write(8'h03);
        exp_q.push_back(beat(1'b1, 1'b0, 1'b0, 8'h00));
        exp_q.push_back(beat(1'b1, 1'b0, 1'b1, 8'h01));
        do_exec(16'h0100, 16'h0000);
        @(negedge clk);
        chk("rww_bksel_adr", 32'(fbus.BkSel), 32'h2);
        chk("rww_rwwsb_busy", 32'(spmcsr_dout), 32'h43);
        watch_op(2'b10, 1'b0, 1'b1, hi, bad);
        chk("rww_erase_len", 32'(hi), 32'(PROG));
        chk("rww_op_cycles", 32'(bad), 32'd0);
        chk("rww_bksel_after", 32'(fbus.BkSel), 32'h0);
        wait_idle("rww_idle");
        chk("rww_rwwsb_after", 32'(spmcsr_dout), 32'h40);
        csr_write(8'h11);
        do_exec(16'h0000, 16'h0000);
        @(negedge clk);
        chk("rwwsre_clears", 32'(spmcsr_dout), 32'h00);
        chk("rwwsre_idle", 32'(spm_busy), 32'd0);

        // NRWW page write with interrupt enabled
        csr_write(8'h80);
        @(negedge clk);
        chk("spmie_only", 32'(spmcsr_dout), 32'h80);
        chk("irq_idle", 32'(spm_irq), 32'd1);
        csr_write(8'h85);
        @(negedge clk);
        chk("irq_armed", 32'(spm_irq), 32'd0);
        exp_q.push_back(beat(1'b1, 1'b0, 1'b0, 8'h80));
        exp_q.push_back(beat(1'b1, 1'b0, 1'b1, 8'h70));
        do_exec(16'h7080, 16'h1234);
        @(negedge clk);
        chk("nrww_halt_adr", 32'({cpu_halt, fbus.BkSel}), 32'h7);
        watch_op(2'b11, 1'b1, 1'b0, hi, bad);
        chk("nrww_prog_len", 32'(hi), 32'(PROG));
        chk("nrww_op_cycles", 32'(bad), 32'd0);
        chk("nrww_halt_after", 32'(cpu_halt), 32'd0);
        wait_idle("nrww_idle");
        chk("nrww_dout", 32'(spmcsr_dout), 32'h80);
        chk("nrww_irq", 32'(spm_irq), 32'd1);
        chk("commits_two", 32'(commits), 32'd2);

        // Reset in the middle of a page write
        csr_write(8'h05);
        exp_q.push_back(beat(1'b1, 1'b0, 1'b0, 8'h00));
        exp_q.push_back(beat(1'b1, 1'b0, 1'b1, 8'h02));
        do_exec(16'h0200, 16'h0000);
        n = 0;
        while (!fbus.Prog && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("abort_prog_started", 32'(fbus.Prog), 32'd1);
        repeat (5) @(posedge clk);
        #2; nrst = 1'b0;
        #1;
        chk("abort_prog", 32'(fbus.Prog), 32'd0);
        chk("abort_bksel", 32'(fbus.BkSel), 32'h0);
        chk("abort_dout", 32'(spmcsr_dout), 32'h00);
        chk("abort_misc", 32'({cpu_halt, spm_busy, spm_irq}), 32'h0);
        repeat (2) @(posedge clk);
        #1; nrst = 1'b1;
        repeat (PROG + 5) @(negedge clk);
        chk("abort_no_commit", 32'(commits), 32'd2);
        chk("abort_prog_stays", 32'(fbus.Prog), 32'd0);
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_buf_kept", 32'({page_buf[70], page_buf[71]}), 32'hEFBE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
